// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and helpers for single-precision operand
// classification.
//   - Flag bit indices for the 6-bit class vector consumed by the FP compare unit.
//   - Bit indices for the RISC-V FCLASS.S mask.
//   - A field-split helper that reduces a 32-bit operand to the few decode bits
//     the classifier needs. Stage S1 registers these bits.
package fp_pkg;

    // Class-flag vector layout (one-hot)
    localparam int FLAGS_W   = 6;
    localparam int FLAG_SNAN = 5;
    localparam int FLAG_QNAN = 4;
    localparam int FLAG_INF  = 3;
    localparam int FLAG_ZERO = 2;
    localparam int FLAG_SUB  = 1;
    localparam int FLAG_NORM = 0;

    // IEEE-754 single-precision field positions
    localparam int         EXP_MSB  = 30;
    localparam int         EXP_LSB  = 23;
    localparam int         MAN_W    = 23;
    localparam int         SIGN_BIT = 31;
    localparam logic [7:0] EXP_ALL1 = 8'hFF;
    localparam logic [7:0] EXP_ALL0 = 8'h00;

    // FCLASS.S mask layout (one-hot)
    localparam int FCLASS_W    = 10;
    localparam int FC_NEG_INF  = 0;
    localparam int FC_NEG_NORM = 1;
    localparam int FC_NEG_SUB  = 2;
    localparam int FC_NEG_ZERO = 3;
    localparam int FC_POS_ZERO = 4;
    localparam int FC_POS_SUB  = 5;
    localparam int FC_POS_NORM = 6;
    localparam int FC_POS_INF  = 7;
    localparam int FC_SNAN     = 8;
    localparam int FC_QNAN     = 9;

    // Minimal field decode of one operand; everything downstream derives from it
    typedef struct packed {
        logic sign;
        logic exp_all1;
        logic exp_all0;
        logic man_zero;
        logic man_msb;
    } fp_fields_t;

    function automatic fp_fields_t fp_split(input logic [31:0] op);
        fp_fields_t f;
        f.sign     = op[SIGN_BIT];
        f.exp_all1 = (op[EXP_MSB:EXP_LSB] == EXP_ALL1);
        f.exp_all0 = (op[EXP_MSB:EXP_LSB] == EXP_ALL0);
        f.man_zero = (op[MAN_W-1:0] == {MAN_W{1'b0}});
        f.man_msb  = op[MAN_W-1];
        return f;
    endfunction

endpackage

// File: rtl/fp_class_decode.sv
// fp_class_decode: purely combinational classifier for one single-precision
// operand, working from the pre-split field decode of its 32 bits.
// Ports:
//   fields_i  field decode of the operand (sign, exp all-ones/all-zeros,
//             mantissa zero, mantissa MSB)
//   flags_o   6-bit one-hot class flags (sNaN/qNaN/inf/zero/sub/normal)
//   fclass_o  10-bit one-hot RISC-V FCLASS.S mask
module fp_class_decode
    import fp_pkg::*;
(
    input  fp_fields_t            fields_i,
    output logic [FLAGS_W-1:0]    flags_o,
    output logic [FCLASS_W-1:0]   fclass_o
);

    // Exactly one flag and one FCLASS bit are set for any encoding.
    // The NaN cases ignore the sign bit.
    always_comb begin
        flags_o  = {FLAGS_W{1'b0}};
        fclass_o = {FCLASS_W{1'b0}};
        if (fields_i.exp_all1) begin
            if (fields_i.man_zero) begin
                flags_o[FLAG_INF] = 1'b1;
                if (fields_i.sign) begin
                    fclass_o[FC_NEG_INF] = 1'b1;
                end else begin
                    fclass_o[FC_POS_INF] = 1'b1;
                end
            end else if (fields_i.man_msb) begin
                flags_o[FLAG_QNAN] = 1'b1;
                fclass_o[FC_QNAN]  = 1'b1;
            end else begin
                flags_o[FLAG_SNAN] = 1'b1;
                fclass_o[FC_SNAN]  = 1'b1;
            end
        end else if (fields_i.exp_all0) begin
            if (fields_i.man_zero) begin
                flags_o[FLAG_ZERO] = 1'b1;
                if (fields_i.sign) begin
                    fclass_o[FC_NEG_ZERO] = 1'b1;
                end else begin
                    fclass_o[FC_POS_ZERO] = 1'b1;
                end
            end else begin
                flags_o[FLAG_SUB] = 1'b1;
                if (fields_i.sign) begin
                    fclass_o[FC_NEG_SUB] = 1'b1;
                end else begin
                    fclass_o[FC_POS_SUB] = 1'b1;
                end
            end
        end else begin
            flags_o[FLAG_NORM] = 1'b1;
            if (fields_i.sign) begin
                fclass_o[FC_NEG_NORM] = 1'b1;
            end else begin
                fclass_o[FC_POS_NORM] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_operand_classifier.sv
// fp_operand_classifier: two-stage pipelined operand classifier that feeds
// the FP compare unit.
//   S1 registers the operands, the tag and the per-operand field decode.
//   S2 registers the class flags, the FCLASS.S mask of a, the operands and
//   the tag. Every out_* port comes straight from an S2 flop.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          synchronous kill of every in-flight entry; an input
//                  offered in the same cycle is dropped
//   in_valid/in_ready, in_a, in_b, in_tag     upstream handshake and payload
//   out_valid/out_ready                       downstream handshake
//   out_a, out_b   operands, unmodified
//   out_a_flags, out_b_flags   6-bit class flags
//   out_a_fclass   FCLASS.S mask of a
//   out_tag        passthrough tag
module fp_operand_classifier
    import fp_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_a,
    input  logic [31:0]           in_b,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_a,
    output logic [31:0]           out_b,
    output logic [FLAGS_W-1:0]    out_a_flags,
    output logic [FLAGS_W-1:0]    out_b_flags,
    output logic [FCLASS_W-1:0]   out_a_fclass,
    output logic [TAG_W-1:0]      out_tag
);

    // Stage S1 state
    logic                  s1_v_q,     s1_v_d;
    logic [31:0]           s1_a_q,     s1_a_d;
    logic [31:0]           s1_b_q,     s1_b_d;
    logic [TAG_W-1:0]      s1_tag_q,   s1_tag_d;
    fp_fields_t            s1_a_fld_q, s1_a_fld_d;
    fp_fields_t            s1_b_fld_q, s1_b_fld_d;

    // Stage S2 state (drives the outputs)
    logic                  s2_v_q,       s2_v_d;
    logic [31:0]           s2_a_q,       s2_a_d;
    logic [31:0]           s2_b_q,       s2_b_d;
    logic [TAG_W-1:0]      s2_tag_q,     s2_tag_d;
    logic [FLAGS_W-1:0]    s2_a_flags_q, s2_a_flags_d;
    logic [FLAGS_W-1:0]    s2_b_flags_q, s2_b_flags_d;
    logic [FCLASS_W-1:0]   s2_a_fc_q,    s2_a_fc_d;

    // Handshake and decode nets
    logic                  s1_adv_s;
    logic                  s2_adv_s;
    logic                  s1_load_s;
    logic                  s2_load_s;
    logic [FLAGS_W-1:0]    a_flags_s;
    logic [FLAGS_W-1:0]    b_flags_s;
    logic [FCLASS_W-1:0]   a_fclass_s;
    // b's FCLASS mask has no consumer; the compare unit needs only b's flags
    logic [FCLASS_W-1:0]   b_fclass_unused_s;

    fp_class_decode u_dec_a (
        .fields_i (s1_a_fld_q),
        .flags_o  (a_flags_s),
        .fclass_o (a_fclass_s)
    );

    fp_class_decode u_dec_b (
        .fields_i (s1_b_fld_q),
        .flags_o  (b_flags_s),
        .fclass_o (b_fclass_unused_s)
    );

    // Advance conditions. A flush blocks both data loads so that killed
    // entries never overwrite the held output payload.
    always_comb begin
        s2_adv_s  = ~s2_v_q | out_ready;
        s1_adv_s  = ~s1_v_q | s2_adv_s;
        s1_load_s = s1_adv_s & in_valid & ~flush;
        s2_load_s = s2_adv_s & s1_v_q & ~flush;
    end

    // in_ready is forced high during reset so that upstream never stalls on a
    // pipeline that is about to be emptied.
    always_comb begin
        in_ready  = rst | s1_adv_s;
        out_valid = s2_v_q;
    end

    // Next-state for the valid bits; a flush empties both stages
    always_comb begin
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_v_d = in_valid;
            end else begin
                s1_v_d = s1_v_q;
            end
            if (s2_adv_s) begin
                s2_v_d = s1_v_q;
            end else begin
                s2_v_d = s2_v_q;
            end
        end
    end

    // Next-state for the S1 payload: capture operands, tag and field decode
    always_comb begin
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        s1_a_fld_d = s1_a_fld_q;
        s1_b_fld_d = s1_b_fld_q;
        if (s1_load_s) begin
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_tag_d   = in_tag;
            s1_a_fld_d = fp_split(in_a);
            s1_b_fld_d = fp_split(in_b);
        end else begin
            s1_a_d     = s1_a_q;
            s1_b_d     = s1_b_q;
            s1_tag_d   = s1_tag_q;
            s1_a_fld_d = s1_a_fld_q;
            s1_b_fld_d = s1_b_fld_q;
        end
    end

    // Next-state for the S2 payload: final classification plus passthrough
    always_comb begin
        s2_a_d       = s2_a_q;
        s2_b_d       = s2_b_q;
        s2_tag_d     = s2_tag_q;
        s2_a_flags_d = s2_a_flags_q;
        s2_b_flags_d = s2_b_flags_q;
        s2_a_fc_d    = s2_a_fc_q;
        if (s2_load_s) begin
            s2_a_d       = s1_a_q;
            s2_b_d       = s1_b_q;
            s2_tag_d     = s1_tag_q;
            s2_a_flags_d = a_flags_s;
            s2_b_flags_d = b_flags_s;
            s2_a_fc_d    = a_fclass_s;
        end else begin
            s2_a_d       = s2_a_q;
            s2_b_d       = s2_b_q;
            s2_tag_d     = s2_tag_q;
            s2_a_flags_d = s2_a_flags_q;
            s2_b_flags_d = s2_b_flags_q;
            s2_a_fc_d    = s2_a_fc_q;
        end
    end

    // Pipeline registers; data flops are cleared on reset so outputs read 0
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q       <= 1'b0;
            s1_a_q       <= 32'h0000_0000;
            s1_b_q       <= 32'h0000_0000;
            s1_tag_q     <= {TAG_W{1'b0}};
            s1_a_fld_q   <= '0;
            s1_b_fld_q   <= '0;
            s2_v_q       <= 1'b0;
            s2_a_q       <= 32'h0000_0000;
            s2_b_q       <= 32'h0000_0000;
            s2_tag_q     <= {TAG_W{1'b0}};
            s2_a_flags_q <= {FLAGS_W{1'b0}};
            s2_b_flags_q <= {FLAGS_W{1'b0}};
            s2_a_fc_q    <= {FCLASS_W{1'b0}};
        end else begin
            s1_v_q       <= s1_v_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_tag_q     <= s1_tag_d;
            s1_a_fld_q   <= s1_a_fld_d;
            s1_b_fld_q   <= s1_b_fld_d;
            s2_v_q       <= s2_v_d;
            s2_a_q       <= s2_a_d;
            s2_b_q       <= s2_b_d;
            s2_tag_q     <= s2_tag_d;
            s2_a_flags_q <= s2_a_flags_d;
            s2_b_flags_q <= s2_b_flags_d;
            s2_a_fc_q    <= s2_a_fc_d;
        end
    end

    // Outputs come directly from the S2 flops
    always_comb begin
        out_a        = s2_a_q;
        out_b        = s2_b_q;
        out_tag      = s2_tag_q;
        out_a_flags  = s2_a_flags_q;
        out_b_flags  = s2_b_flags_q;
        out_a_fclass = s2_a_fc_q;
    end

endmodule

// File: tb/tb_fp_operand_classifier.sv
// Scoreboard bench for fp_operand_classifier. The stimulus pushes the
// hand-computed expected result of every accepted pair into a queue. A
// monitor compares the queue head with the outputs whenever out_valid is
// high, and pops the head when out_ready is also high.
module tb_fp_operand_classifier;

    localparam int TAG_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_a;
    logic [31:0]       out_b;
    logic [5:0]        out_a_flags;
    logic [5:0]        out_b_flags;
    logic [9:0]        out_a_fclass;
    logic [TAG_W-1:0]  out_tag;

    fp_operand_classifier #(.TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_a        (out_a),
        .out_b        (out_b),
        .out_a_flags  (out_a_flags),
        .out_b_flags  (out_b_flags),
        .out_a_fclass (out_a_fclass),
        .out_tag      (out_tag)
    );

    always #5 clk = ~clk;

    // Directed operand table with hand-computed classes
    logic [31:0] op_tab  [12] = '{32'h3F800000, 32'h7F800001, 32'hFF800000, 32'h80000000,
                                  32'h00000001, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                  32'hBF800000, 32'h807FFFFF, 32'hFFC00001, 32'h7FBFFFFF};
    logic [5:0]  flg_tab [12] = '{6'b000001, 6'b100000, 6'b001000, 6'b000100,
                                  6'b000010, 6'b010000, 6'b001000, 6'b000100,
                                  6'b000001, 6'b000010, 6'b010000, 6'b100000};
    logic [9:0]  fc_tab  [12] = '{10'h040, 10'h100, 10'h001, 10'h008,
                                  10'h020, 10'h200, 10'h080, 10'h010,
                                  10'h002, 10'h004, 10'h200, 10'h100};

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [5:0]       af;
        logic [5:0]       bf;
        logic [9:0]       fc;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    bit   lat_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compare the queue head while valid, retire it on handshake
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q[0];
                chk("out_a",        out_a,                 e.a);
                chk("out_b",        out_b,                 e.b);
                chk("out_a_flags",  {26'd0, out_a_flags},  {26'd0, e.af});
                chk("out_b_flags",  {26'd0, out_b_flags},  {26'd0, e.bf});
                chk("out_a_fclass", {22'd0, out_a_fclass}, {22'd0, e.fc});
                chk("out_tag",      {27'd0, out_tag},      {27'd0, e.tag});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (e.lat) chk("latency", cyc - e.acc, 32'd2);
                end
            end
        end
    end

    // Offer one pair; returns at posedge+1 after it has been accepted
    task automatic send(input int ai, input int bi, input int tag);
        exp_t e;
        bit   done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = op_tab[ai];
        in_b     = op_tab[bi];
        in_tag   = tag[TAG_W-1:0];
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.a   = op_tab[ai];
                e.b   = op_tab[bi];
                e.af  = flg_tab[ai];
                e.bf  = flg_tab[bi];
                e.fc  = fc_tab[ai];
                e.tag = tag[TAG_W-1:0];
                e.acc = cyc;
                e.lat = lat_en;
                exp_q.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    // Wait, bounded, until every expected result has been retired
    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  {31'd0, out_valid},      32'd0);
        chk("rst_in_ready",   {31'd0, in_ready},       32'd1);
        chk("rst_out_a",      out_a,                   32'd0);
        chk("rst_out_tag",    {27'd0, out_tag},        32'd0);
        chk("rst_out_flags",  {26'd0, out_a_flags},    32'd0);
        chk("rst_out_fclass", {22'd0, out_a_fclass},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single op: 1.0 against an sNaN
        lat_en = 1'b1;
        send(0, 1, 1);
        drain();

        // Class sweep of a (and b)
        send(2, 7, 2);
        send(3, 6, 3);
        send(4, 8, 4);
        send(5, 9, 5);
        drain();

        // Back-to-back stream of 8 pairs, tags 0..7
        for (int i = 0; i < 8; i++) send(i % 12, (i + 5) % 12, i);
        drain();

        // Backpressure: full pipeline, out_ready low for 5 cycles
        lat_en    = 1'b0;
        out_ready = 1'b0;
        send(10, 11, 10);
        send(11, 0, 11);
        in_valid = 1'b1;
        in_a     = op_tab[1];
        in_b     = op_tab[2];
        in_tag   = 5'd12;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready},  32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1, 2, 12);
        drain();

        // Flush with two entries in flight plus a new offer
        out_ready = 1'b0;
        send(3, 4, 20);
        send(5, 6, 21);
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_a      = op_tab[7];
        in_b      = op_tab[8];
        in_tag    = 5'd22;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        lat_en = 1'b1;
        send(8, 9, 23);
        drain();

        // Reset mid-stream with both stages valid
        lat_en    = 1'b0;
        out_ready = 1'b0;
        send(0, 5, 24);
        send(6, 7, 25);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("postrst_in_ready",  {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("postrst_idle", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk);
        #1;
        lat_en = 1'b1;
        send(11, 10, 26);
        drain();

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
